// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures an asynchronous pulse train in the clk domain. For each full
//   cycle of the input it reports the period (rise to rise) and the high
//   time (rise to fall) as counts of clk cycles, and strobes meas_valid
//   for one cycle whenever those results update.
//
// Parameters
//   CNT_W        width of the counters and of period/high_time
//   SYNC_STAGES  synchronizer depth for pulse_in (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   pulse_in    asynchronous pulse train under measurement
//   enable      1 = measure, 0 = idle and drop any partial measurement
//   period      clk cycles between the last two detected rising edges
//   high_time   clk cycles from a detected rise to the following fall
//   meas_valid  one-cycle strobe when period/high_time update
//   timeout     sticky: counter saturated without seeing a rising edge
module pulse_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s_d_reg;
   logic                   s, rise, fall;

   logic [CNT_W-1:0] cnt_reg, hi_cnt_reg, cnt_inc;
   logic             fell_reg;
   logic [CNT_W-1:0] period_reg, high_time_reg;
   logic             meas_valid_reg, timeout_reg;

   // Decoded control from the FSM
   logic clr_cnt, take_meas, saturate, count_en;

   // Synchronizer: shift pulse_in through SYNC_STAGES flops, then one more
   // flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
         s_d_reg  <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], pulse_in};
         s_d_reg  <= s;
      end
   end

   assign s       = sync_reg[SYNC_STAGES-1];
   assign rise    = s & ~s_d_reg;
   assign fall    = ~s & s_d_reg;
   assign cnt_inc = cnt_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      clr_cnt    = 1'b0;
      take_meas  = 1'b0;
      saturate   = 1'b0;
      count_en   = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         clr_cnt    = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               clr_cnt    = 1'b1;
               state_next = ARM;
            end
            ARM: begin
               // The first rise only opens the measurement window.
               if (rise) begin
                  clr_cnt    = 1'b1;
                  state_next = MEASURE;
               end
            end
            MEASURE: begin
               // A rise wins over saturation in the same cycle, so a
               // period of exactly 2^CNT_W reports as a truncated value.
               if (rise) begin
                  take_meas = 1'b1;
               end else if (cnt_reg == CNT_MAX) begin
                  saturate   = 1'b1;
                  state_next = ARM;
               end else begin
                  count_en = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               clr_cnt    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         hi_cnt_reg     <= '0;
         fell_reg       <= 1'b0;
         period_reg     <= '0;
         high_time_reg  <= '0;
         meas_valid_reg <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         meas_valid_reg <= 1'b0;
         if (!enable) begin
            timeout_reg <= 1'b0;
         end
         if (clr_cnt) begin
            cnt_reg    <= '0;
            hi_cnt_reg <= '0;
            fell_reg   <= 1'b0;
         end else if (take_meas) begin
            period_reg     <= cnt_inc;
            // Without a fall inside the window the input never went low,
            // so the whole period counts as high time.
            high_time_reg  <= fell_reg ? hi_cnt_reg : cnt_inc;
            meas_valid_reg <= 1'b1;
            timeout_reg    <= 1'b0;
            cnt_reg        <= '0;
            hi_cnt_reg     <= '0;
            fell_reg       <= 1'b0;
         end else if (saturate) begin
            timeout_reg <= 1'b1;
            cnt_reg     <= '0;
         end else if (count_en) begin
            cnt_reg <= cnt_inc;
            if (fall) begin
               hi_cnt_reg <= cnt_inc;
               fell_reg   <= 1'b1;
            end
         end
      end
   end

   assign period     = period_reg;
   assign high_time  = high_time_reg;
   assign meas_valid = meas_valid_reg;
   assign timeout    = timeout_reg;

endmodule
